// File: rtl/axi_manager.sv
// Single-outstanding AXI4 manager: turns one host read/write command into one
// single-beat AXI4 transaction and reports completion with a one-cycle pulse.
module axi_manager #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [ID_WIDTH-1:0]   awid,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic [3:0]            awqos,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [7:0]            wstrb,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  input  logic [ID_WIDTH-1:0]   bid,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic                  rlast,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RESP
  } state_t;

  state_t                r_state, w_next;
  logic                  r_cmd_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [7:0]            r_wstrb;
  logic                  r_err, r_aw_done, r_w_done;

  logic                  w_misaligned;
  logic [7:0]            w_strb_base;
  logic [DATA_WIDTH-1:0] w_rmask, w_rshift;
  logic                  w_unused;

  // A transfer happens on a channel in the cycle where valid && ready are both
  // high at the rising edge; a valid, once raised, holds with stable payload
  // until that cycle, and ready never waits on anything but our own state.

  always_comb begin
    w_misaligned = 1'b0;
    w_strb_base  = 8'h01;
    case (cmd_size)
      2'd0: begin w_misaligned = 1'b0;             w_strb_base = 8'h01; end
      2'd1: begin w_misaligned = cmd_addr[0];      w_strb_base = 8'h03; end
      2'd2: begin w_misaligned = |cmd_addr[1:0];   w_strb_base = 8'h0F; end
      default: begin w_misaligned = |cmd_addr[2:0]; w_strb_base = 8'hFF; end
    endcase
  end

  always_comb begin
    w_rmask = '1;
    case (r_size)
      2'd0:    w_rmask = DATA_WIDTH'(8'hFF);
      2'd1:    w_rmask = DATA_WIDTH'(16'hFFFF);
      2'd2:    w_rmask = DATA_WIDTH'(32'hFFFF_FFFF);
      default: w_rmask = '1;
    endcase
  end

  assign w_rshift = rdata >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_next    = r_state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          if (w_misaligned)   w_next = S_RESP;
          else if (cmd_write) w_next = S_WRITE;
          else                w_next = S_RD_ADDR;
        end
      end
      S_WRITE: begin
        awvalid = !r_aw_done;
        wvalid  = !r_w_done;
        if ((r_aw_done || awready) && (r_w_done || wready)) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) w_next = S_RESP;
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      r_state     <= w_next;
      // cmd_ready is registered so it stays low while reset is asserted
      r_cmd_ready <= (w_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_addr    <= cmd_addr;
            r_size    <= cmd_size;
            r_wdata   <= cmd_wdata << {cmd_addr[2:0], 3'b000};
            r_wstrb   <= w_strb_base << cmd_addr[2:0];
            r_rdata   <= '0;
            r_err     <= w_misaligned;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_WRITE: begin
          if (awvalid && awready) r_aw_done <= 1'b1;
          if (wvalid && wready)   r_w_done  <= 1'b1;
        end
        S_WR_RESP: if (bvalid) r_err <= (bresp != 2'b00);
        S_RD_DATA: begin
          if (rvalid) begin
            r_rdata <= w_rshift & w_rmask;
            r_err   <= (rresp != 2'b00);
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_rdata = r_rdata;
  assign rsp_error = r_err;
  assign dbg_state = r_state;

  assign awaddr  = r_addr;
  assign awid    = '0;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, r_size};
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awqos   = 4'd0;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = wvalid;

  assign araddr  = r_addr;
  assign arid    = '0;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, r_size};
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arqos   = 4'd0;

  assign w_unused = ^{bid, rid, rlast};

endmodule

// File: tb/tb_axi_manager.sv
// Bench for axi_manager: byte-addressed reference memory plus a reactive AXI
// subordinate; a monitor checks every response and AXI request against queues.
module tb_axi_manager;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          awvalid, awready, awlock;
  logic [AW-1:0] awaddr;
  logic [IW-1:0] awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize, awprot;
  logic [1:0]    awburst;
  logic [3:0]    awcache, awqos;
  logic          wvalid, wready, wlast;
  logic [DW-1:0] wdata;
  logic [7:0]    wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic [IW-1:0] bid;
  logic          arvalid, arready, arlock;
  logic [AW-1:0] araddr;
  logic [IW-1:0] arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst;
  logic [3:0]    arcache, arqos;
  logic          rvalid, rready, rlast;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [IW-1:0] rid;
  logic [2:0]    dbg_state;

  axi_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rid(rid), .rlast(rlast), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [64:0] exp_q[$];      // {rsp_error, rsp_rdata}
  logic [34:0] exp_aw_q[$];   // {addr, size}
  logic [71:0] exp_w_q[$];    // {wdata, wstrb}
  logic [34:0] exp_ar_q[$];   // {addr, size}
  logic [1:0]  resp_q[$];     // response code the subordinate will return

  logic [7:0] ref_mem[int unsigned];
  logic [7:0] sub_mem[int unsigned];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [31:0] a);
    return sub_mem.exists(a) ? sub_mem[a] : init_byte(a);
  endfunction

  // ---------------- subordinate ----------------
  int mode = 0;   // 0 random, 1 zero-wait, 2 awready stalled, 3 slow B
  int aw_seen, w_seen, ar_seen, aw_thr, w_thr, ar_thr;
  int b_cnt, b_dly, r_cnt, r_dly;
  bit s_aw_got, s_w_got, b_pend, r_pend;
  logic [31:0] s_awaddr, s_araddr;
  logic [63:0] s_wdata, n_rdata;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic n_awready, n_wready, n_arready, n_bvalid, n_rvalid;

  function automatic int pick_aw();
    if (mode == 0) return $urandom_range(0, 3);
    if (mode == 2) return 3;
    return 0;
  endfunction

  function automatic int pick_rdy();
    return (mode == 0) ? int'($urandom_range(0, 3)) : 0;
  endfunction

  function automatic int pick_dly();
    if (mode == 0) return $urandom_range(0, 3);
    if (mode == 3) return 30;
    return 0;
  endfunction

  function automatic void set_mode(input int m);
    mode   = m;
    aw_thr = pick_aw();
    w_thr  = pick_rdy();
    ar_thr = pick_rdy();
  endfunction

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rid = '0; rlast = 0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        s_aw_got = 0; s_w_got = 0; b_pend = 0; r_pend = 0;
        resp_q.delete();
        n_awready = 0; n_wready = 0; n_arready = 0; n_bvalid = 0; n_rvalid = 0;
      end else begin
        if (awvalid && awready) begin
          s_awaddr = awaddr; s_aw_got = 1; aw_seen = 0; aw_thr = pick_aw();
        end else if (awvalid) aw_seen++;
        if (wvalid && wready) begin
          s_wdata = wdata; s_wstrb = wstrb; s_w_got = 1; w_seen = 0; w_thr = pick_rdy();
        end else if (wvalid) w_seen++;
        if (bvalid && bready) b_pend = 0;
        if (s_aw_got && s_w_got) begin
          s_aw_got = 0; s_w_got = 0;
          s_bresp = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
          if (s_bresp == 2'b00)
            for (int j = 0; j < 8; j++)
              if (s_wstrb[j]) sub_mem[{s_awaddr[31:3], 3'b000} + j] = s_wdata[8*j +: 8];
          b_pend = 1; b_cnt = 0; b_dly = pick_dly();
        end
        n_bvalid = bvalid && !bready;
        if (b_pend && !n_bvalid) begin
          if (b_cnt >= b_dly) n_bvalid = 1; else b_cnt++;
        end
        if (rvalid && rready) r_pend = 0;
        if (arvalid && arready) begin
          s_araddr = araddr; ar_seen = 0; ar_thr = pick_rdy();
          s_rresp = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
          for (int j = 0; j < 8; j++) n_rdata[8*j +: 8] = sub_byte({araddr[31:3], 3'b000} + j);
          r_pend = 1; r_cnt = 0; r_dly = pick_dly();
        end else if (arvalid) ar_seen++;
        n_rvalid = rvalid && !rready;
        if (r_pend && !n_rvalid) begin
          if (r_cnt >= r_dly) n_rvalid = 1; else r_cnt++;
        end
        n_awready = (aw_seen >= aw_thr);
        n_wready  = (w_seen >= w_thr);
        n_arready = (ar_seen >= ar_thr);
      end
      @(posedge aclk);
      #1;
      if (areset_n) begin
        awready = n_awready; wready = n_wready; arready = n_arready;
        bvalid = n_bvalid; bresp = s_bresp;
        rvalid = n_rvalid; rdata = n_rdata; rresp = s_rresp; rlast = n_rvalid;
      end else begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int n_rsp = 0;
  int acc_cyc, last_rsp_cyc, aw_cnt, w_cnt, last_aw_len, last_w_len;
  bit pv_aw, pv_w, pv_ar;
  logic [35:0] pv_aw_p, pv_ar_p;
  logic [72:0] pv_w_p;
  logic [64:0] e_rsp;

  initial begin
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        pv_aw = 0; pv_w = 0; pv_ar = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (rsp_valid) begin
          n_rsp++;
          last_rsp_cyc = cyc;
          check("cmd_ready_in_resp", cmd_ready, 1'b0);
          if (exp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
          else begin
            e_rsp = exp_q.pop_front();
            check("rsp", {rsp_error, rsp_rdata}, e_rsp);
          end
        end
        if (pv_aw) check("aw_hold", {awvalid, awaddr, awsize}, pv_aw_p);
        if (pv_w)  check("w_hold", {wvalid, wdata, wstrb}, pv_w_p);
        if (pv_ar) check("ar_hold", {arvalid, araddr, arsize}, pv_ar_p);
        if (awvalid) begin
          aw_cnt++;
          if (exp_aw_q.size() == 0) check("aw_unexpected", 1'b1, 1'b0);
          else if (awready) begin
            check("aw", {awaddr, awsize}, exp_aw_q.pop_front());
            check("aw_static", {awid, awlen, awburst, awlock, awcache, awprot, awqos},
                  {4'h0, 8'h00, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});
            last_aw_len = aw_cnt; aw_cnt = 0;
          end
        end
        if (wvalid) begin
          w_cnt++;
          if (exp_w_q.size() == 0) check("w_unexpected", 1'b1, 1'b0);
          else if (wready) begin
            check("w", {wdata, wstrb}, exp_w_q.pop_front());
            check("wlast", wlast, 1'b1);
            last_w_len = w_cnt; w_cnt = 0;
          end
        end
        if (arvalid) begin
          if (exp_ar_q.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
          else if (arready) begin
            check("ar", {araddr, arsize}, exp_ar_q.pop_front());
            check("ar_static", {arid, arlen, arburst, arlock, arcache, arprot, arqos},
                  {4'h0, 8'h00, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0});
          end
        end
        pv_aw = awvalid && !awready; pv_aw_p = {1'b1, awaddr, awsize};
        pv_w  = wvalid && !wready;   pv_w_p  = {1'b1, wdata, wstrb};
        pv_ar = arvalid && !arready; pv_ar_p = {1'b1, araddr, arsize};
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [63:0] data, input bit inj);
    int nb;
    logic [63:0] dm, rd;
    logic [15:0] strb;
    logic [1:0]  code;
    bit ok;
    nb   = 1 << size;
    dm   = (nb == 8) ? data : (data & ((64'h1 << (8 * nb)) - 1));
    code = inj ? ($urandom_range(0, 1) ? 2'b10 : 2'b11) : 2'b00;
    if ((addr % nb) != 0) begin
      exp_q.push_back({1'b1, 64'h0});
    end else if (wr) begin
      strb = ((16'h1 << nb) - 16'h1) << addr[2:0];
      exp_aw_q.push_back({addr, 1'b0, size});
      exp_w_q.push_back({dm << (8 * addr[2:0]), strb[7:0]});
      resp_q.push_back(code);
      if (!inj) for (int i = 0; i < nb; i++) ref_mem[addr + i] = dm[8*i +: 8];
      exp_q.push_back({inj, 64'h0});
    end else begin
      rd = '0;
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_byte(addr + i);
      exp_ar_q.push_back({addr, 1'b0, size});
      resp_q.push_back(code);
      exp_q.push_back({inj, rd});
    end
    @(posedge aclk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = dm;
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1; break; end
    end
    check("cmd_accept", ok, 1'b1);
    @(posedge aclk); #1;
    cmd_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(posedge aclk);
    check("drain", exp_q.size(), 0);
    @(posedge aclk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  int r0;
  bit got_b;
  logic [31:0] ra;
  logic [1:0]  rs;

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    areset_n = 0;
    set_mode(0);
    idle(3);
    check("reset_outs", {awvalid, wvalid, arvalid, bready, rready, cmd_ready, rsp_valid,
                         rsp_error, rsp_rdata, awaddr, araddr, wdata, wstrb}, '0);
    areset_n = 1;
    idle(2);

    issue(1, 32'h10C0, 2'd1, 64'h0100, 0);
    issue(0, 32'h10C0, 2'd1, 64'h0, 0);
    drain();
    for (int i = 0; i < 8; i++) begin
      ref_mem[32'h1018 + i] = 8'(8'h11 * (i + 1));
      sub_mem[32'h1018 + i] = 8'(8'h11 * (i + 1));
    end
    issue(0, 32'h1018, 2'd1, 64'h0, 0);
    issue(0, 32'h101A, 2'd1, 64'h0, 0);
    drain();
    issue(1, 32'h10C0, 2'd2, 64'h200, 0);
    issue(0, 32'h10C0, 2'd2, 64'h0, 0);
    issue(1, 32'h1000, 2'd3, 64'h400, 0);
    issue(0, 32'h1000, 2'd3, 64'h0, 0);
    drain();

    set_mode(1);
    idle(3);
    issue(0, 32'h101C, 2'd2, 64'h0, 0);
    drain();
    check("read_latency", last_rsp_cyc - acc_cyc, 3);
    idle(2);
    issue(1, 32'h1020, 2'd0, 64'h5A, 0);
    drain();
    check("write_latency", last_rsp_cyc - acc_cyc, 3);

    set_mode(2);
    idle(3);
    r0 = n_rsp;
    issue(1, 32'h1040, 2'd2, 64'hDEAD_BEEF, 0);
    drain();
    idle(3);
    check("aw_stall_len", last_aw_len, 4);
    check("w_len", last_w_len, 1);
    check("single_rsp", n_rsp - r0, 1);

    set_mode(0);
    issue(0, 32'h1018, 2'd1, 64'h0, 1);
    issue(0, 32'h1001, 2'd1, 64'h0, 0);
    issue(1, 32'h1003, 2'd2, 64'h77, 0);
    issue(1, 32'h1044, 2'd2, 64'h1234_5678, 1);
    drain();

    for (int i = 0; i < 150; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = 32'h2000 + $urandom_range(0, 63);
      if ($urandom_range(0, 99) < 85) ra = ra & ~((32'h1 << rs) - 1);
      issue(1'($urandom_range(0, 1)), ra, rs, {$urandom, $urandom}, $urandom_range(0, 9) == 0);
    end
    drain();

    set_mode(3);
    issue(1, 32'h1080, 2'd1, 64'h1234, 0);
    got_b = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (bready) begin got_b = 1; break; end
    end
    check("reach_wr_resp", got_b, 1'b1);
    #2 areset_n = 0;
    #1 check("reset_abort", {bready, rsp_valid, cmd_ready}, 3'b000);
    exp_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    idle(3);
    areset_n = 1;
    set_mode(0);
    idle(2);
    issue(0, 32'h1080, 2'd1, 64'h0, 0);
    drain();
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
